// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters,
// common to the transmitter and receiver.
package fifo_uart_tx_pkg;

    localparam int unsigned UART_DBIT_DEFAULT    = 8;
    localparam int unsigned UART_SB_TICK_DEFAULT = 16;

    // Last tick index of a 16x-oversampled start or data bit.
    localparam logic [4:0] UART_BIT_LAST_TICK = 5'd15;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StData  = 2'b10,
        StStop  = 2'b11
    } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a first-word fall-through FIFO. It pops one word per
// frame and shifts it out LSB first on a registered, glitch-free serial line.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned DBIT    = UART_DBIT_DEFAULT,
    parameter int unsigned SB_TICK = UART_SB_TICK_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tick,
    input  logic            i_empty,
    input  logic [DBIT-1:0] i_r_data,
    output logic            o_rd,
    output logic            o_tx,
    output logic            o_tx_busy,
    output logic            o_tx_done_tick
);

    localparam logic [4:0] STOP_LAST_TICK = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT       = 3'(DBIT - 1);

    uart_state_e     r_state;
    logic [4:0]      r_s;
    logic [2:0]      r_n;
    logic [DBIT-1:0] r_b;
    logic            r_tx;

    logic [DBIT-1:0] w_b_shift;
    logic            w_idle;
    logic            w_stop_end;

    assign w_b_shift  = r_b >> 1;
    assign w_idle     = (r_state == StIdle);
    assign w_stop_end = (r_state == StStop) && i_tick && (r_s == STOP_LAST_TICK);

    // Gated by reset so that no pop is issued while the block is held in reset.
    assign o_rd           = i_reset && w_idle && !i_empty;
    assign o_tx           = r_tx;
    assign o_tx_busy      = !w_idle;
    assign o_tx_done_tick = w_stop_end;

    // r_tx always takes the line value of the state being entered.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_s     <= 5'd0;
            r_n     <= 3'd0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!i_empty) begin
                        r_b     <= i_r_data;
                        r_s     <= 5'd0;
                        r_tx    <= 1'b0;
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (i_tick) begin
                        if (r_s == UART_BIT_LAST_TICK) begin
                            r_s     <= 5'd0;
                            r_n     <= 3'd0;
                            r_tx    <= r_b[0];
                            r_state <= StData;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                StData: begin
                    if (i_tick) begin
                        if (r_s == UART_BIT_LAST_TICK) begin
                            r_s <= 5'd0;
                            r_b <= w_b_shift;
                            if (r_n == LAST_BIT) begin
                                r_tx    <= 1'b1;
                                r_state <= StStop;
                            end else begin
                                r_n  <= r_n + 3'd1;
                                r_tx <= w_b_shift[0];
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                StStop: begin
                    if (i_tick) begin
                        if (r_s == STOP_LAST_TICK) begin
                            r_tx    <= 1'b1;
                            r_state <= StIdle;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
